// File: rtl/axi_ram_responder.sv
// rtl/axi_ram_responder.sv - single-beat AXI3 slave RAM with fixed read/write response latencies
module axi_ram_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int RD_DELAY   = 2,
    parameter int WR_DELAY   = 1
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    localparam logic [7:0] R_CNT_INIT = (RD_DELAY > 0) ? 8'(RD_DELAY - 1) : 8'd0;
    localparam logic [7:0] W_CNT_INIT = (WR_DELAY > 0) ? 8'(WR_DELAY - 1) : 8'd0;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, araddr[1:0],
                             araddr[31:ADDR_WIDTH+2], awsize, awburst, awlock, awcache,
                             awprot, awaddr[1:0], awaddr[31:ADDR_WIDTH+2], wid, wlast};

    // ---------------- read channel ----------------
    r_state_t              r_state, r_next;
    logic [7:0]            r_cnt;
    logic [3:0]            rid_q;
    logic [ADDR_WIDTH-1:0] r_idx_q;
    logic                  r_err_q;
    logic [31:0]           rdata_q;
    logic [1:0]            rresp_q;
    logic                  r_load;
    logic [ADDR_WIDTH-1:0] r_load_idx;
    logic                  r_load_err;
    logic                  ar_fire;

    assign ar_fire = (r_state == R_IDLE) && arvalid;

    always_comb begin
        r_next     = r_state;
        r_load     = 1'b0;
        r_load_idx = r_idx_q;
        r_load_err = r_err_q;
        case (r_state)
            R_IDLE: begin
                r_load_idx = araddr[ADDR_WIDTH+1:2];
                r_load_err = (arlen != 8'd0);
                if (arvalid) begin
                    if (RD_DELAY == 0) begin
                        r_next = R_RESP;
                        r_load = 1'b1;
                    end else begin
                        r_next = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt == 8'd0) begin
                    r_next = R_RESP;
                    r_load = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Response data is captured on entry to R_RESP so it stays stable while stalled.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_cnt   <= 8'd0;
            rid_q   <= 4'd0;
            r_idx_q <= '0;
            r_err_q <= 1'b0;
            rdata_q <= 32'd0;
            rresp_q <= 2'b00;
        end else begin
            if (ar_fire) begin
                rid_q   <= arid;
                r_idx_q <= araddr[ADDR_WIDTH+1:2];
                r_err_q <= (arlen != 8'd0);
                r_cnt   <= R_CNT_INIT;
            end else if (r_state == R_WAIT && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (r_load) begin
                rdata_q <= r_load_err ? 32'd0 : mem[r_load_idx];
                rresp_q <= r_load_err ? 2'b10 : 2'b00;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t              w_state, w_next;
    logic [7:0]            w_cnt;
    logic                  aw_got, w_got;
    logic [3:0]            awid_q;
    logic [ADDR_WIDTH-1:0] aw_idx_q;
    logic                  aw_err_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            bresp_q;
    logic                  aw_fire, w_fire, commit;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic                  c_err;
    logic [31:0]           c_data;
    logic [3:0]            c_strb;

    assign aw_fire = (w_state == W_IDLE) && !aw_got && awvalid;
    assign w_fire  = (w_state == W_IDLE) && !w_got && wvalid;
    assign commit  = (w_state == W_IDLE) && (aw_got || awvalid) && (w_got || wvalid);

    // The later of AW/W is used straight from the bus on its acceptance edge.
    assign c_idx  = aw_got ? aw_idx_q : awaddr[ADDR_WIDTH+1:2];
    assign c_err  = aw_got ? aw_err_q : (awlen != 8'd0);
    assign c_data = w_got ? wdata_q : wdata;
    assign c_strb = w_got ? wstrb_q : wstrb;

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_next = (WR_DELAY == 0) ? W_RESP : W_WAIT;
            W_WAIT: if (w_cnt == 8'd0) w_next = W_RESP;
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            w_cnt    <= 8'd0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            awid_q   <= 4'd0;
            aw_idx_q <= '0;
            aw_err_q <= 1'b0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            bresp_q  <= 2'b00;
        end else begin
            if (aw_fire) begin
                awid_q   <= awid;
                aw_idx_q <= awaddr[ADDR_WIDTH+1:2];
                aw_err_q <= (awlen != 8'd0);
            end
            if (w_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                aw_got  <= 1'b0;
                w_got   <= 1'b0;
                bresp_q <= c_err ? 2'b10 : 2'b00;
                w_cnt   <= W_CNT_INIT;
            end else begin
                if (aw_fire) aw_got <= 1'b1;
                if (w_fire)  w_got  <= 1'b1;
                if (w_state == W_WAIT && w_cnt != 8'd0) w_cnt <= w_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (commit && !reset && !c_err) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    // ---------------- outputs (forced low while reset is held) ----------------
    assign arready = !reset && (r_state == R_IDLE);
    assign rvalid  = !reset && (r_state == R_RESP);
    assign rlast   = rvalid;
    assign rid     = reset ? 4'd0 : rid_q;
    assign rdata   = reset ? 32'd0 : rdata_q;
    assign rresp   = reset ? 2'b00 : rresp_q;
    assign awready = !reset && (w_state == W_IDLE) && !aw_got;
    assign wready  = !reset && (w_state == W_IDLE) && !w_got;
    assign bvalid  = !reset && (w_state == W_RESP);
    assign bid     = reset ? 4'd0 : awid_q;
    assign bresp   = reset ? 2'b00 : bresp_q;

endmodule
